// File: rtl/i3c_target_responder.sv
// I3C target endpoint: ENTDAA, GETCAPS and RSTDAA responder plus idle-bus In-Band Interrupt requester.
// SCL/SDA are oversampled on clk; SDA is open-drain, so sda_oe=1 pulls the line low.
module i3c_target_responder #(
  parameter logic [7:0]  STATIC_ADDR     = 8'h50,
  parameter logic [7:0]  BCR_VAL         = 8'h06,
  parameter logic [7:0]  DCR_VAL         = 8'h00,
  parameter logic [7:0]  LVR_VAL         = 8'h00,
  parameter int unsigned BUS_FREE_CYCLES = 16,
  parameter int unsigned IBI_TIMEOUT     = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [6:0] dyn_addr,
  output logic       da_valid,
  input  logic       ibi_req,
  output logic       ibi_busy,
  output logic       ibi_done,
  output logic       ibi_timeout,
  output logic       ccc_err
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CMD       = 4'd1;
  localparam logic [3:0] S_CMD_ACK   = 4'd2;
  localparam logic [3:0] S_DAA_TX    = 4'd3;
  localparam logic [3:0] S_DAA_RX    = 4'd4;
  localparam logic [3:0] S_DAA_ACK   = 4'd5;
  localparam logic [3:0] S_ADDR      = 4'd6;
  localparam logic [3:0] S_ADDR_ACK  = 4'd7;
  localparam logic [3:0] S_CAP_TX    = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;
  localparam logic [3:0] S_IBI       = 4'd10;

  localparam int unsigned FREE_W = $clog2(BUS_FREE_CYCLES + 1);
  localparam int unsigned IBI_W  = $clog2(IBI_TIMEOUT + 1);
  localparam logic [FREE_W-1:0] FREE_MAX = FREE_W'(BUS_FREE_CYCLES);
  localparam logic [IBI_W-1:0]  IBI_LAST = IBI_W'(IBI_TIMEOUT - 1);

  logic              r_scl_s1, r_scl_s2, r_scl_d;
  logic              r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]        r_state, r_next;
  logic [5:0]        r_bit_cnt, r_tx_len;
  logic [7:0]        r_rx;
  logic [31:0]       r_tx;
  logic [FREE_W-1:0] r_free_cnt;
  logic [IBI_W-1:0]  r_ibi_cnt;
  logic              r_sda_oe, r_da_valid, r_ccc_err, r_ibi_done, r_ibi_timeout;
  logic [6:0]        r_dyn_addr;

  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

  assign sda_oe      = r_sda_oe;
  assign dyn_addr    = r_dyn_addr;
  assign da_valid    = r_da_valid;
  assign ibi_busy    = (r_state == S_IBI);
  assign ibi_done    = r_ibi_done;
  assign ibi_timeout = r_ibi_timeout;
  assign ccc_err     = r_ccc_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= '1;
      {r_sda_s1, r_sda_s2, r_sda_d} <= '1;
      r_state       <= S_IDLE;
      r_next        <= S_IDLE;
      r_bit_cnt     <= '0;
      r_tx_len      <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_free_cnt    <= '0;
      r_ibi_cnt     <= '0;
      r_sda_oe      <= 1'b0;
      r_da_valid    <= 1'b0;
      r_dyn_addr    <= '0;
      r_ccc_err     <= 1'b0;
      r_ibi_done    <= 1'b0;
      r_ibi_timeout <= 1'b0;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_ccc_err     <= 1'b0;
      r_ibi_done    <= 1'b0;
      r_ibi_timeout <= 1'b0;

      if (r_state == S_IDLE && r_scl_s2 && r_sda_s2) begin
        if (r_free_cnt != FREE_MAX) r_free_cnt <= r_free_cnt + 1'b1;
      end else begin
        r_free_cnt <= '0;
      end

      // Our own IBI drive looks like START (and its release like STOP), so framing is ignored in IBI.
      if (r_state != S_IBI && w_start) begin
        r_state   <= S_CMD;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else if (r_state != S_IBI && w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_free_cnt == FREE_MAX && ibi_req && r_da_valid) begin
              r_state   <= S_IBI;
              r_sda_oe  <= 1'b1;
              r_ibi_cnt <= '0;
            end
          end
          S_CMD, S_DAA_RX, S_ADDR: begin
            if (w_scl_rise) begin
              r_rx      <= {r_rx[6:0], r_sda_s2};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end else if (w_scl_fall && r_bit_cnt == 6'd8) begin
              r_bit_cnt <= '0;
              r_state   <= S_WAIT_STOP;
              if (r_state == S_CMD) begin
                case (r_rx)
                  8'h07: if (!r_da_valid) begin
                    r_sda_oe <= 1'b1;
                    r_state  <= S_CMD_ACK;
                    r_next   <= S_DAA_TX;
                  end
                  8'h08: begin
                    r_sda_oe <= 1'b1;
                    r_state  <= S_CMD_ACK;
                    r_next   <= S_ADDR;
                  end
                  8'h06: begin
                    r_sda_oe   <= 1'b1;
                    r_state    <= S_CMD_ACK;
                    r_next     <= S_WAIT_STOP;
                    r_da_valid <= 1'b0;
                    r_dyn_addr <= '0;
                  end
                  default: r_ccc_err <= 1'b1;
                endcase
              end else if (r_state == S_DAA_RX) begin
                r_dyn_addr <= r_rx[6:0];
                r_da_valid <= 1'b1;
                r_sda_oe   <= 1'b1;
                r_state    <= S_DAA_ACK;
                r_next     <= S_WAIT_STOP;
              end else if (r_rx[7:1] == r_dyn_addr && !r_rx[0] && r_da_valid) begin
                r_sda_oe <= 1'b1;
                r_state  <= S_ADDR_ACK;
                r_next   <= S_CAP_TX;
              end else begin
                r_ccc_err <= 1'b1;
              end
            end
          end
          S_CMD_ACK, S_DAA_ACK, S_ADDR_ACK: begin
            if (w_scl_rise) begin
              r_bit_cnt <= 6'd1;
            end else if (w_scl_fall && r_bit_cnt != 6'd0) begin
              // The fall that ends the ACK also presents the first transmit bit.
              r_bit_cnt <= '0;
              r_state   <= r_next;
              r_sda_oe  <= 1'b0;
              if (r_next == S_DAA_TX) begin
                r_tx     <= {BCR_VAL, DCR_VAL, LVR_VAL, STATIC_ADDR};
                r_tx_len <= 6'd32;
                r_sda_oe <= ~BCR_VAL[7];
              end else if (r_next == S_CAP_TX) begin
                r_tx     <= {BCR_VAL, DCR_VAL, LVR_VAL, 8'h00};
                r_tx_len <= 6'd24;
                r_sda_oe <= ~BCR_VAL[7];
              end
            end
          end
          S_DAA_TX, S_CAP_TX: begin
            if (w_scl_rise) begin
              if (r_state == S_DAA_TX && r_tx[31] && !r_sda_s2) begin
                r_sda_oe  <= 1'b0;
                r_ccc_err <= 1'b1;
                r_state   <= S_WAIT_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end else if (w_scl_fall && r_bit_cnt != 6'd0) begin
              if (r_bit_cnt == r_tx_len) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= (r_state == S_DAA_TX) ? S_DAA_RX : S_WAIT_STOP;
              end else begin
                r_tx     <= {r_tx[30:0], 1'b0};
                r_sda_oe <= ~r_tx[30];
              end
            end
          end
          S_WAIT_STOP: r_sda_oe <= 1'b0;
          S_IBI: begin
            if (!r_scl_s2) begin
              r_ibi_done <= 1'b1;
              r_sda_oe   <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_ibi_cnt == IBI_LAST) begin
              r_ibi_timeout <= 1'b1;
              r_sda_oe      <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_ibi_cnt <= r_ibi_cnt + 1'b1;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
